// File: rtl/ttl245_bus_arbiter.sv
// Purpose : round-robin owner of a shared data bus fronted by NUM_REQ 74LS245 transceivers.
// Latency : grant 1 cycle after req, OE_n low after TURNAROUND_CYCLES more, ready after SETTLE_CYCLES more.
// Backpress: requesters hold req until done; ready drops on release, direction change or reset.
//
// Ports:
//   i_clk      system clock, rising edge
//   i_reset    synchronous active-high reset
//   i_req      per-requester bus request (level, held for whole transfer)
//   i_dir_req  per-requester direction, 1 = A to B, 0 = B to A
//   o_grant    one-hot registered grant
//   o_ready    granted path enabled and settled
//   o_busy     arbiter not idle
//   o_oe_n     per-transceiver output enable, active low
//   o_dir      per-transceiver DIR pin
module ttl245_bus_arbiter #(
   parameter int NUM_REQ           = 4,
   parameter int TURNAROUND_CYCLES = 2,
   parameter int SETTLE_CYCLES     = 1
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [NUM_REQ-1:0] i_dir_req,
   output logic [NUM_REQ-1:0] o_grant,
   output logic               o_ready,
   output logic               o_busy,
   output logic [NUM_REQ-1:0] o_oe_n,
   output logic [NUM_REQ-1:0] o_dir
);

   localparam int PW      = $clog2(NUM_REQ);
   localparam int CNT_MAX = (TURNAROUND_CYCLES > SETTLE_CYCLES) ? TURNAROUND_CYCLES : SETTLE_CYCLES;
   localparam int CW      = $clog2(CNT_MAX + 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_TURN   = 2'd1,
      S_SETTLE = 2'd2,
      S_ACTIVE = 2'd3
   } state_t;

   state_t             r_state, w_state;
   logic [CW-1:0]      r_cnt, w_cnt;
   logic [PW-1:0]      r_ptr, w_ptr;
   logic [PW-1:0]      r_sel, w_sel;
   logic [NUM_REQ-1:0] r_grant, w_grant;
   logic               r_ready, w_ready;
   logic [NUM_REQ-1:0] r_oe_n, w_oe_n;
   logic [NUM_REQ-1:0] r_dir, w_dir;

   logic               w_any;
   logic [PW-1:0]      w_pick;
   int                 w_idx;

   // First set request at or after the pointer. Scanning from the far end
   // downwards lets the closest candidate overwrite the others.
   always_comb begin : rr_pick
      w_any  = 1'b0;
      w_pick = '0;
      w_idx  = 0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         w_idx = int'(r_ptr) + i;
         if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
         if (i_req[w_idx]) begin
            w_any  = 1'b1;
            w_pick = PW'(w_idx);
         end
      end
   end

   always_comb begin : fsm_next
      w_state = r_state;
      w_cnt   = r_cnt;
      w_ptr   = r_ptr;
      w_sel   = r_sel;
      w_grant = r_grant;
      w_ready = r_ready;
      w_oe_n  = r_oe_n;
      w_dir   = r_dir;
      case (r_state)
         S_IDLE: begin
            if (w_any) begin
               w_sel          = w_pick;
               w_grant        = '0;
               w_grant[w_pick] = 1'b1;
               w_dir[w_pick]  = i_dir_req[w_pick];
               w_cnt          = CW'(TURNAROUND_CYCLES - 1);
               w_state        = S_TURN;
            end
         end
         default: begin
            if (!i_req[r_sel]) begin
               // Release wins over everything; DIR is left where it was.
               w_state = S_IDLE;
               w_grant = '0;
               w_oe_n  = '1;
               w_ready = 1'b0;
               w_ptr   = (r_sel == PW'(NUM_REQ - 1)) ? '0 : r_sel + 1'b1;
            end else if (r_state == S_TURN) begin
               // OE_n is still high, so DIR may track the request freely.
               w_dir[r_sel] = i_dir_req[r_sel];
               if (r_cnt == '0) begin
                  w_oe_n[r_sel] = 1'b0;
                  w_cnt         = CW'(SETTLE_CYCLES - 1);
                  w_state       = S_SETTLE;
               end else begin
                  w_cnt = r_cnt - 1'b1;
               end
            end else if (i_dir_req[r_sel] != r_dir[r_sel]) begin
               // Never flip DIR under an enabled 245: disable, flip, redo turnaround.
               w_oe_n[r_sel] = 1'b1;
               w_ready       = 1'b0;
               w_dir[r_sel]  = i_dir_req[r_sel];
               w_cnt         = CW'(TURNAROUND_CYCLES - 1);
               w_state       = S_TURN;
            end else if (r_state == S_SETTLE) begin
               if (r_cnt == '0) begin
                  w_ready = 1'b1;
                  w_state = S_ACTIVE;
               end else begin
                  w_cnt = r_cnt - 1'b1;
               end
            end
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_ptr   <= '0;
         r_sel   <= '0;
         r_grant <= '0;
         r_ready <= 1'b0;
         r_oe_n  <= '1;
         r_dir   <= '0;
      end else begin
         r_state <= w_state;
         r_cnt   <= w_cnt;
         r_ptr   <= w_ptr;
         r_sel   <= w_sel;
         r_grant <= w_grant;
         r_ready <= w_ready;
         r_oe_n  <= w_oe_n;
         r_dir   <= w_dir;
      end
   end

   assign o_grant = r_grant;
   assign o_ready = r_ready;
   assign o_busy  = (r_state != S_IDLE);
   assign o_oe_n  = r_oe_n;
   assign o_dir   = r_dir;

endmodule

// File: tb/tb_ttl245_bus_arbiter.sv
// Purpose : directed bench for ttl245_bus_arbiter with a 245/bus model and invariant monitor.
// Latency : checks exact grant/OE_n/ready timing against hand-computed cycle counts.
// Backpress: requesters hold req until they choose to release.
module tb_ttl245_bus_arbiter;

   localparam int N = 4;

   logic         clk = 1'b0;
   logic         reset;
   logic [N-1:0] req;
   logic [N-1:0] dir_req;
   logic [N-1:0] grant;
   logic         ready;
   logic         busy;
   logic [N-1:0] oe_n;
   logic [N-1:0] dir;

   int total = 0;
   int bad   = 0;
   logic mon_en = 1'b0;

   always #5 clk = ~clk;

   ttl245_bus_arbiter #(
      .NUM_REQ(N),
      .TURNAROUND_CYCLES(2),
      .SETTLE_CYCLES(1)
   ) dut (
      .i_clk    (clk),
      .i_reset  (reset),
      .i_req    (req),
      .i_dir_req(dir_req),
      .o_grant  (grant),
      .o_ready  (ready),
      .o_busy   (busy),
      .o_oe_n   (oe_n),
      .o_dir    (dir)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready(input string tag);
      int n = 0;
      while (ready !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      check(tag, {31'd0, ready}, 32'd1);
   endtask

   // Bus model: each 245 A side is a segment driven with fresh data every
   // cycle; the shared B side takes whatever enabled A-to-B transceiver drives it.
   logic [7:0] a_seg [N];
   logic [7:0] b_bus;
   logic [7:0] exp_b;

   always @(posedge clk)
      for (int i = 0; i < N; i++) a_seg[i] <= 8'($urandom);

   always_comb begin
      b_bus = 8'hxx;
      exp_b = 8'h00;
      for (int i = 0; i < N; i++) begin
         if (!oe_n[i] && dir[i]) b_bus = a_seg[i];
         if (grant[i]) exp_b = a_seg[i];
      end
   end

   logic [N-1:0] prev_oe_n = '1;
   logic [N-1:0] prev_dir  = '0;

   always @(negedge clk) begin
      if (mon_en) begin
         check("inv_one_oe", {31'd0, $countones(~oe_n) <= 1}, 32'd1);
         check("inv_oe_granted", {28'd0, ~oe_n & ~grant}, 32'd0);
         check("inv_dir_stable", {28'd0, (dir ^ prev_dir) & ~oe_n & ~prev_oe_n}, 32'd0);
         if (ready) begin
            check("inv_rdy_grant", {31'd0, $onehot(grant)}, 32'd1);
            check("inv_rdy_oe", {28'd0, ~oe_n}, {28'd0, grant});
            if (|(dir & grant)) check("bus_b_eq_a", {24'd0, b_bus}, {24'd0, exp_b});
         end
         prev_oe_n <= oe_n;
         prev_dir  <= dir;
      end
   end

   initial begin
      logic [N-1:0] exp_g;
      int gap;

      reset   = 1'b1;
      req     = '0;
      dir_req = '0;
      tick();
      tick();
      check("rst_grant", {28'd0, grant}, 32'h0);
      check("rst_ready", {31'd0, ready}, 32'h0);
      check("rst_busy",  {31'd0, busy},  32'h0);
      check("rst_oe_n",  {28'd0, oe_n},  32'hF);
      check("rst_dir",   {28'd0, dir},   32'h0);
      reset  = 1'b0;
      mon_en = 1'b1;

      // 1: single request, exact latency
      req = 4'b0001; dir_req = 4'b0001;
      tick();
      check("t1_grant", {28'd0, grant}, 32'h1);
      check("t1_dir",   {28'd0, dir},   32'h1);
      check("t1_oe_e1", {28'd0, oe_n},  32'hF);
      check("t1_busy",  {31'd0, busy},  32'h1);
      tick();
      check("t1_oe_e2", {28'd0, oe_n},  32'hF);
      tick();
      check("t1_oe_e3", {28'd0, oe_n},  32'hE);
      check("t1_rdy_e3", {31'd0, ready}, 32'h0);
      tick();
      check("t1_rdy_e4", {31'd0, ready}, 32'h1);
      req = '0;
      tick();
      check("t1_rel_oe",    {28'd0, oe_n},  32'hF);
      check("t1_rel_ready", {31'd0, ready}, 32'h0);
      check("t1_rel_grant", {28'd0, grant}, 32'h0);
      check("t1_rel_dir",   {28'd0, dir},   32'h1);

      // 2: round-robin from pointer 0 with all requesting
      reset = 1'b1; dir_req = '0;
      tick();
      reset = 1'b0;
      req = 4'b1111;
      tick();
      for (int g = 0; g < 5; g++) begin
         exp_g = 4'b0001 << (g % 4);
         check("t2_grant", {28'd0, grant}, {28'd0, exp_g});
         wait_ready("t2_ready");
         req = 4'b1111 & ~exp_g;
         tick();
         check("t2_rel_grant", {28'd0, grant}, 32'h0);
         check("t2_rel_oe",    {28'd0, oe_n},  32'hF);
         if (g < 4) begin
            req = 4'b1111;
            gap = 1;
            for (int n = 0; n < 10 && oe_n == 4'hF; n++) begin
               tick();
               if (oe_n == 4'hF) gap++;
            end
            check("t2_gap", gap, 3);
         end else begin
            req = '0;
         end
      end

      // 3: direction change on channel 2 while active
      req = 4'b0100; dir_req = 4'b0000;
      tick();
      check("t3_grant", {28'd0, grant}, 32'h4);
      wait_ready("t3_ready0");
      check("t3_dir0", {28'd0, dir}, 32'h0);
      dir_req = 4'b0100;
      tick();
      check("t3_oe_off", {28'd0, oe_n},  32'hF);
      check("t3_rdy_off", {31'd0, ready}, 32'h0);
      check("t3_dir1",   {28'd0, dir},   32'h4);
      check("t3_grant1", {28'd0, grant}, 32'h4);
      tick();
      check("t3_oe_t1",  {28'd0, oe_n},  32'hF);
      check("t3_grant2", {28'd0, grant}, 32'h4);
      tick();
      check("t3_oe_on",  {28'd0, oe_n},  32'hB);
      check("t3_rdy_on0", {31'd0, ready}, 32'h0);
      tick();
      check("t3_rdy_on1", {31'd0, ready}, 32'h1);
      check("t3_grant3", {28'd0, grant}, 32'h4);
      req = '0;
      tick();
      check("t3_rel", {28'd0, grant}, 32'h0);

      // 4: abort in TURN; pointer moves past the aborted channel
      req = 4'b0001; dir_req = '0;
      tick();
      check("t4_pre_grant", {28'd0, grant}, 32'h1);
      req = '0;
      tick();
      req = 4'b1011;
      tick();
      check("t4_grant1", {28'd0, grant}, 32'h2);
      req = 4'b1001;
      tick();
      check("t4_abort_grant", {28'd0, grant}, 32'h0);
      check("t4_abort_oe",    {28'd0, oe_n},  32'hF);
      check("t4_abort_busy",  {31'd0, busy},  32'h0);
      tick();
      check("t4_next_grant", {28'd0, grant}, 32'h8);
      req = '0;
      tick();

      // 5: reset while active; pointer back to 0
      req = 4'b0100;
      tick();
      wait_ready("t5_ready_c2");
      req = '0;
      tick();
      req = 4'b0010; dir_req = 4'b0010;
      tick();
      check("t5_grant_c1", {28'd0, grant}, 32'h2);
      wait_ready("t5_ready_c1");
      req = 4'b1010;
      reset = 1'b1;
      tick();
      check("t5_rst_grant", {28'd0, grant}, 32'h0);
      check("t5_rst_ready", {31'd0, ready}, 32'h0);
      check("t5_rst_busy",  {31'd0, busy},  32'h0);
      check("t5_rst_oe",    {28'd0, oe_n},  32'hF);
      check("t5_rst_dir",   {28'd0, dir},   32'h0);
      reset = 1'b0;
      tick();
      check("t5_regrant", {28'd0, grant}, 32'h2);
      check("t5_redir",   {28'd0, dir},   32'h2);
      wait_ready("t5_ready_again");
      req = '0;
      tick();
      tick();
      mon_en = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
